// File: rtl/pkt_sched_pkg.sv
// Shared constants for the packet tag scheduler: FSM encoding, channel IDs,
// parameter defaults and the interval-number step helper.
package pkt_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [7:0] CH0 = 8'd0;
  localparam logic [7:0] CH1 = 8'd1;

  localparam int unsigned GAP_DEF     = 32'd2;
  localparam logic [15:0] INT_MAX_DEF = 16'd999;

  // Next interval number; wraps to zero after max_v.
  function automatic logic [15:0] next_interval(input logic [15:0] cur,
                                                input logic [15:0] max_v);
    logic [15:0] nxt;
    if (cur == max_v) begin
      nxt = 16'd0;
    end else begin
      nxt = cur + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. ptr names the channel that wins a tie;
// the owner flips it to the loser after every grant.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic sel
);

  // Pick a channel: tie goes to ptr, otherwise the only requester.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) begin
      sel = ptr;
    end else if (req1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
  end

endmodule

// File: rtl/packet_tag_scheduler.sv
// Interval tracker plus two-channel grant scheduler with a forced gap after
// every grant; all outputs come straight from flops.
module packet_tag_scheduler
  import pkt_sched_pkg::*;
#(
  parameter int unsigned GAP     = GAP_DEF,
  parameter logic [15:0] INT_MAX = INT_MAX_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pps,
  input  logic        int_start,
  input  logic        en,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ev,
  output logic [7:0]  n_ch,
  output logic [15:0] Numb_inter,
  output logic        cnt_clr,
  output logic        int_wrap
);

  // The last GAP cycle doubles as an arbitration cycle, so grants land GAP+1 apart.
  localparam logic [3:0] GAP_LOAD = (GAP == 32'd0) ? 4'd0 : 4'(GAP - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        ev_q, ev_d;
  logic [7:0]  n_ch_q, n_ch_d;
  logic [15:0] numb_q, numb_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        wrap_q, wrap_d;
  logic        arb_sel;
  logic        can_grant;
  logic        grant_now;

  rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .ptr  (rr_ptr_q),
    .sel  (arb_sel)
  );

  assign can_grant = en & (req0 | req1) & ~pps & ~int_start;
  assign grant_now = can_grant &
                     ((state_q == ST_IDLE) | ((state_q == ST_GAP) & (gap_cnt_q == 4'd0)));

  // Next-state logic for interval tracking, FSM and grant outputs.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    n_ch_d    = n_ch_q;
    numb_d    = numb_q;
    wrap_d    = wrap_q;
    cnt_clr_d = pps | int_start;

    if (pps) begin
      numb_d = 16'd0;
      wrap_d = 1'b0;
    end else if (int_start) begin
      numb_d = next_interval(numb_q, INT_MAX);
      wrap_d = wrap_q | (numb_q == INT_MAX);
    end else begin
      numb_d = numb_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (can_grant) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (GAP != 32'd0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (can_grant) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = 4'd0;
      end
    endcase

    if (grant_now) begin
      gnt0_d   = ~arb_sel;
      gnt1_d   = arb_sel;
      n_ch_d   = arb_sel ? CH1 : CH0;
      rr_ptr_d = ~arb_sel;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    ev_d = gnt0_d | gnt1_d;
  end

  // State and output registers; clr overrides everything and pulses cnt_clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 4'd0;
      rr_ptr_q  <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ev_q      <= 1'b0;
      n_ch_q    <= CH0;
      numb_q    <= 16'd0;
      cnt_clr_q <= 1'b1;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      ev_q      <= ev_d;
      n_ch_q    <= n_ch_d;
      numb_q    <= numb_d;
      cnt_clr_q <= cnt_clr_d;
      wrap_q    <= wrap_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign ev         = ev_q;
  assign n_ch       = n_ch_q;
  assign Numb_inter = numb_q;
  assign cnt_clr    = cnt_clr_q;
  assign int_wrap   = wrap_q;

endmodule

// File: tb/tb_packet_tag_scheduler.sv
// Directed bench for packet_tag_scheduler (GAP=2, INT_MAX=3) with a
// cycle-level reference model compared on every falling edge.
module tb_packet_tag_scheduler;

  localparam int          GAP     = 2;
  localparam logic [15:0] INT_MAX = 16'd3;
  localparam int          SPACING = (GAP == 0) ? 1 : GAP;

  logic        clk = 1'b0;
  logic        clr, pps, int_start, en, req0, req1;
  logic        gnt0, gnt1, ev, cnt_clr, int_wrap;
  logic [7:0]  n_ch;
  logic [15:0] Numb_inter;

  int vectors = 0;
  int miscompares = 0;

  packet_tag_scheduler #(.GAP(GAP), .INT_MAX(INT_MAX)) dut (
    .clk(clk), .clr(clr), .pps(pps), .int_start(int_start), .en(en),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1), .ev(ev),
    .n_ch(n_ch), .Numb_inter(Numb_inter), .cnt_clr(cnt_clr), .int_wrap(int_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: interval counter plus "grants at least SPACING decision
  // cycles apart", round-robin on ties, blocked by strobes, disabled by en.
  logic        m_valid = 1'b0;
  int          m_cyc = 0;
  int          m_last_g = -1000;
  logic [15:0] m_numb = 16'd0;
  logic        m_wrap = 1'b0, m_cc = 1'b0, m_g0 = 1'b0, m_g1 = 1'b0, m_prio = 1'b0;
  logic [7:0]  m_nch = 8'd0;

  always @(posedge clk) begin : model
    int          ch;
    logic [15:0] n;
    logic        w;
    if (clr) begin
      m_valid  <= 1'b1;
      m_numb   <= 16'd0;
      m_wrap   <= 1'b0;
      m_cc     <= 1'b1;
      m_g0     <= 1'b0;
      m_g1     <= 1'b0;
      m_nch    <= 8'd0;
      m_prio   <= 1'b0;
      m_last_g <= -1000;
    end else begin
      n = m_numb;
      w = m_wrap;
      if (pps) begin
        n = 16'd0;
        w = 1'b0;
      end else if (int_start) begin
        if (m_numb == INT_MAX) begin
          n = 16'd0;
          w = 1'b1;
        end else begin
          n = m_numb + 16'd1;
        end
      end
      m_numb <= n;
      m_wrap <= w;
      m_cc   <= pps | int_start;
      if (en && (req0 || req1) && !pps && !int_start && (m_cyc - m_last_g >= SPACING)) begin
        if (req0 && req1) ch = int'(m_prio);
        else if (req1)    ch = 1;
        else              ch = 0;
        m_g0     <= (ch == 0);
        m_g1     <= (ch == 1);
        m_nch    <= 8'(ch);
        m_prio   <= (ch == 0);
        m_last_g <= m_cyc + 1;
      end else begin
        m_g0 <= 1'b0;
        m_g1 <= 1'b0;
      end
    end
    m_cyc <= m_cyc + 1;
  end

  // Every cycle after the first clr, the DUT must match the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_gnt0", 32'(gnt0), 32'(m_g0));
      check("cmp_gnt1", 32'(gnt1), 32'(m_g1));
      check("cmp_ev", 32'(ev), 32'(m_g0 | m_g1));
      check("cmp_n_ch", 32'(n_ch), 32'(m_nch));
      check("cmp_numb", 32'(Numb_inter), 32'(m_numb));
      check("cmp_cnt_clr", 32'(cnt_clr), 32'(m_cc));
      check("cmp_wrap", 32'(int_wrap), 32'(m_wrap));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] int_seq [4];
    int          exp_cyc [4];
    int          exp_ch  [4];
    int          g_cyc[$];
    int          g_ch[$];
    int          waited;
    logic        found;

    int_seq = '{16'd1, 16'd2, 16'd3, 16'd0};
    exp_cyc = '{1, 4, 7, 10};
    exp_ch  = '{0, 1, 0, 1};

    clr = 1'b0; pps = 1'b0; int_start = 1'b0; en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // Reset state
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("rst_numb", 32'(Numb_inter), 32'd0);
    check("rst_cnt_clr", 32'(cnt_clr), 32'd1);
    check("rst_wrap", 32'(int_wrap), 32'd0);
    check("rst_ev", 32'(ev), 32'd0);
    check("rst_n_ch", 32'(n_ch), 32'd0);
    step();
    check("rst_cnt_clr_single", 32'(cnt_clr), 32'd0);

    // pps then four interval starts: 0,1,2,3,wrap to 0
    pps = 1'b1;
    step();
    pps = 1'b0;
    check("pps_numb", 32'(Numb_inter), 32'd0);
    check("pps_cnt_clr", 32'(cnt_clr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      int_start = 1'b1;
      step();
      int_start = 1'b0;
      check("int_numb", 32'(Numb_inter), 32'(int_seq[i]));
      check("int_cnt_clr", 32'(cnt_clr), 32'd1);
      check("int_wrap_flag", 32'(int_wrap), (i == 3) ? 32'd1 : 32'd0);
      step();
      check("int_cnt_clr_drop", 32'(cnt_clr), 32'd0);
    end
    step();
    check("wrap_sticky", 32'(int_wrap), 32'd1);
    int_start = 1'b1;
    step();
    int_start = 1'b0;
    check("wrap_kept_numb", 32'(Numb_inter), 32'd1);
    check("wrap_kept", 32'(int_wrap), 32'd1);

    // pps together with int_start: pps wins, one cnt_clr pulse
    pps = 1'b1; int_start = 1'b1;
    step();
    pps = 1'b0; int_start = 1'b0;
    check("both_numb", 32'(Numb_inter), 32'd0);
    check("both_cnt_clr", 32'(cnt_clr), 32'd1);
    check("both_wrap_clr", 32'(int_wrap), 32'd0);
    step();
    check("both_cnt_clr_single", 32'(cnt_clr), 32'd0);

    // Round robin with both requests held
    en = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (gnt0 || gnt1) begin
        g_cyc.push_back(k);
        g_ch.push_back(int'(n_ch));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_count", 32'(g_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rr_cycle", (g_cyc.size() > i) ? 32'(g_cyc[i]) : 32'hFFFF_FFFF, 32'(exp_cyc[i]));
      check("rr_chan", (g_ch.size() > i) ? 32'(g_ch[i]) : 32'hFFFF_FFFF, 32'(exp_ch[i]));
    end
    step(); step(); step();

    // Request coinciding with int_start waits one cycle
    req0 = 1'b1; int_start = 1'b1;
    step();
    int_start = 1'b0;
    check("coinc_cnt_clr", 32'(cnt_clr), 32'd1);
    check("coinc_no_ev", 32'(ev), 32'd0);
    step();
    req0 = 1'b0;
    check("coinc_gnt0", 32'(gnt0), 32'd1);
    check("coinc_ev", 32'(ev), 32'd1);
    check("coinc_cnt_clr_low", 32'(cnt_clr), 32'd0);

    // clr during GAP with req1 pending
    req1 = 1'b1;
    step(); step(); step();
    check("pre_clr_gnt1", 32'(gnt1), 32'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_gap_no_gnt1", 32'(gnt1), 32'd0);
    check("clr_gap_no_ev", 32'(ev), 32'd0);
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    check("after_clr_gnt0", 32'(gnt0), 32'd1);
    check("after_clr_gnt1", 32'(gnt1), 32'd0);
    found = 1'b0;
    waited = 0;
    while (!found && waited < 8) begin
      step();
      waited++;
      if (gnt1) found = 1'b1;
    end
    req1 = 1'b0;
    check("after_clr_gnt1_seen", 32'(found), 32'd1);
    check("after_clr_gnt1_delay", 32'(waited), 32'd3);
    step(); step(); step();

    // en=0 holds the request without granting
    en = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("en0_no_ev", 32'(ev), 32'd0);
    end
    en = 1'b1;
    step();
    req0 = 1'b0;
    check("en1_gnt0", 32'(gnt0), 32'd1);

    // A request dropped during the gap is owed nothing
    step();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dropped_no_gnt1", 32'(gnt1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
